fp_exp_align: RTL
=================

// Module: fp_exp_align
// PURPOSE
//  Exponent-compare and mantissa-alignment stage of the FP adder datapath.
//  - Takes two unpacked operands (exponent plus mantissa with the hidden bit).
//  - Forms the exponent difference with an 8-bit two's-complement negate-and-add.
//  - Selects the larger exponent and shifts the smaller operand's mantissa right,
//    one bit per clock, accumulating guard/round/sticky bits.
//  - Feeds the mantissa add/sub stage through a valid/ready handshake.
// PARAMETERS
//  EXP_W  8   exponent width (biased, unsigned)
//  MAN_W  24  mantissa width including hidden bit
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          synchronous, active-low reset
//  in_valid   in   1          operand pair valid
//  in_ready   out  1          stage can accept an operand pair
//  exp_a      in   EXP_W      operand A exponent
//  man_a      in   MAN_W      operand A mantissa
//  exp_b      in   EXP_W      operand B exponent
//  man_b      in   MAN_W      operand B mantissa
//  out_valid  out  1          aligned result valid
//  out_ready  in   1          downstream accepts result
//  exp_max    out  EXP_W      larger exponent
//  man_big    out  MAN_W      mantissa of the larger-exponent operand, unshifted
//  man_sml    out  MAN_W+3    smaller mantissa shifted right: {mantissa, G, R, S}
//  swapped    out  1          1 = B had the larger exponent (man_big = man_b)
//  shift_amt  out  EXP_W      applied shift count, clamped to MAN_W+3
// BEHAVIOUR
//  - Reset: if rst_n is low at a clk edge, state goes to IDLE. All outputs and
//    registers go to 0, except in_ready, which is 1 after reset.
//    Reset wins at any point and aborts an in-flight operation without producing a result.
//  - FSM: IDLE -> DIFF -> (SHIFT)* -> DONE -> IDLE.
//  - IDLE: in_ready=1. On in_valid&&in_ready, register operands, go to DIFF.
//  - DIFF (1 cycle), in_ready=0:
//    - d9 = {0,exp_a} + {1,~exp_b} + 1 (9-bit); d9[8]=1 means exp_a >= exp_b.
//    - If exp_b > exp_a: swapped=1 and mag = ~d9[7:0]+1. Otherwise swapped=0 and mag = d9[7:0].
//    - Equal exponents give swapped=0.
//    - Load exp_max, man_big, and man_sml = {smaller mantissa, 3'b000}.
//    - Set cnt = min(mag, MAN_W+3) and shift_amt = cnt.
//    - Next state is DONE if cnt==0, else SHIFT.
//  - SHIFT, one bit per cycle:
//    - man_sml <= {0, man_sml[MAN_W+2:2], man_sml[1]|man_sml[0]}. The sticky bit ORs in every bit shifted past R.
//    - cnt <= cnt-1. Go to DONE when cnt==1 (this is the last shift).
//  - DONE: out_valid=1. All outputs hold stable until out_valid&&out_ready, then go to IDLE.
//    in_ready stays 0, so there is no overlap or skid; one operation is in flight at a time.
//  - Latency: acceptance edge to out_valid high is 2 + cnt cycles (min 2, max MAN_W+5).
//    Throughput is one operation per (3 + cnt + downstream stall) cycles.
//  - Clamp: when mag >= MAN_W+3, the full mantissa ends up in S only.
//    Result is man_sml = {0..0, S = |smaller mantissa}.
//  - Full negate range: exp_a=0, exp_b=255 gives mag=255 with no overflow, clamped to 27.
//  - out_ready held high in DONE: result is taken in 1 cycle; IDLE follows with in_ready=1.
//  - out_ready low: DONE holds indefinitely. in_valid is ignored outside IDLE.
// TESTING
//  T1 equal exp: exp_a=exp_b=8'h80, man_a=24'hC00000, man_b=24'hA00000
//     -> out_valid 2 cycles after accept; swapped=0, shift_amt=0, man_sml={24'hA00000,3'b000}.
//  T2 swap: exp_a=8'h7E, exp_b=8'h80, man_a=24'h800001
//     -> swapped=1, exp_max=8'h80, shift_amt=2, man_sml={24'h200000,3'b010}; latency 4.
//  T3 clamp/sticky: exp_a=8'hFF, exp_b=8'h00, man_b=24'h000001
//     -> shift_amt=27, man_sml=27'h0000001 (S only); latency 29.
//  T4 backpressure: hold out_ready=0 for 10 cycles in DONE
//     -> outputs stable, in_ready=0, extra in_valid ignored; release -> IDLE next cycle.
//  T5 reset mid-shift: rst_n=0 during SHIFT of T3
//     -> next edge: out_valid=0, in_ready=1, all data outputs 0; no result emitted.
//  T6 back-to-back: in_valid held high with out_ready=1 over two operand pairs
//     -> both results delivered in order, each with correct swapped/shift_amt.

Source files
------------

// File: rtl/fp_exp_align_if.sv
// Operand/result handshake bundle for the FP adder exponent-align stage.
// The master drives operands and out_ready; the slave returns the aligned result.
interface fp_exp_align_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [EXP_W-1:0] exp_a;
  logic [MAN_W-1:0] man_a;
  logic [EXP_W-1:0] exp_b;
  logic [MAN_W-1:0] man_b;
  logic             out_valid;
  logic             out_ready;
  logic [EXP_W-1:0] exp_max;
  logic [MAN_W-1:0] man_big;
  logic [MAN_W+2:0] man_sml;
  logic             swapped;
  logic [EXP_W-1:0] shift_amt;

  modport master (
    output in_valid, exp_a, man_a, exp_b, man_b, out_ready,
    input  in_ready, out_valid, exp_max, man_big, man_sml, swapped, shift_amt
  );

  modport slave (
    input  in_valid, exp_a, man_a, exp_b, man_b, out_ready,
    output in_ready, out_valid, exp_max, man_big, man_sml, swapped, shift_amt
  );
endinterface

// File: rtl/fp_exp_align.sv
// FP adder exponent compare and serial mantissa alignment with guard/round/sticky.
// One operation in flight; the smaller mantissa shifts right one bit per clock.
module fp_exp_align #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  fp_exp_align_if.slave bus
);

  localparam logic [EXP_W-1:0] SHIFT_MAX = EXP_W'(MAN_W + 3);

  typedef enum logic [1:0] {IDLE, DIFF, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [EXP_W-1:0] exp_a_q, exp_a_d;
  logic [EXP_W-1:0] exp_b_q, exp_b_d;
  logic [MAN_W-1:0] man_a_q, man_a_d;
  logic [MAN_W-1:0] man_b_q, man_b_d;
  logic [EXP_W-1:0] exp_max_q, exp_max_d;
  logic [MAN_W-1:0] man_big_q, man_big_d;
  logic [MAN_W+2:0] man_sml_q, man_sml_d;
  logic             swapped_q, swapped_d;
  logic [EXP_W-1:0] shift_amt_q, shift_amt_d;
  logic [EXP_W-1:0] cnt_q, cnt_d;

  logic [EXP_W:0]   d9;
  logic             a_ge_b;
  logic [EXP_W-1:0] mag;
  logic [EXP_W-1:0] cnt_sat;

  function automatic logic [EXP_W-1:0] sat_shift(input logic [EXP_W-1:0] m);
    return (m > SHIFT_MAX) ? SHIFT_MAX : m;
  endfunction

  // Right shift by one; whatever leaves the round position is folded into sticky.
  function automatic logic [MAN_W+2:0] shr_sticky(input logic [MAN_W+2:0] v);
    return {1'b0, v[MAN_W+2:2], v[1] | v[0]};
  endfunction

  // Carry out of exp_a + ~exp_b + 1 is set exactly when exp_a >= exp_b.
  always_comb begin
    d9      = {1'b0, exp_a_q} + {1'b0, ~exp_b_q} + (EXP_W+1)'(1);
    a_ge_b  = d9[EXP_W];
    mag     = a_ge_b ? d9[EXP_W-1:0] : (~d9[EXP_W-1:0] + EXP_W'(1));
    cnt_sat = sat_shift(mag);
  end

  always_comb begin
    state_d     = state_q;
    exp_a_d     = exp_a_q;
    exp_b_d     = exp_b_q;
    man_a_d     = man_a_q;
    man_b_d     = man_b_q;
    exp_max_d   = exp_max_q;
    man_big_d   = man_big_q;
    man_sml_d   = man_sml_q;
    swapped_d   = swapped_q;
    shift_amt_d = shift_amt_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          exp_a_d = bus.exp_a;
          exp_b_d = bus.exp_b;
          man_a_d = bus.man_a;
          man_b_d = bus.man_b;
          state_d = DIFF;
        end
      end
      DIFF: begin
        swapped_d   = ~a_ge_b;
        exp_max_d   = a_ge_b ? exp_a_q : exp_b_q;
        man_big_d   = a_ge_b ? man_a_q : man_b_q;
        man_sml_d   = {(a_ge_b ? man_b_q : man_a_q), 3'b000};
        cnt_d       = cnt_sat;
        shift_amt_d = cnt_sat;
        state_d     = (cnt_sat == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        man_sml_d = shr_sticky(man_sml_q);
        cnt_d     = cnt_q - EXP_W'(1);
        if (cnt_q == EXP_W'(1)) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      exp_a_q     <= '0;
      exp_b_q     <= '0;
      man_a_q     <= '0;
      man_b_q     <= '0;
      exp_max_q   <= '0;
      man_big_q   <= '0;
      man_sml_q   <= '0;
      swapped_q   <= 1'b0;
      shift_amt_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      exp_a_q     <= exp_a_d;
      exp_b_q     <= exp_b_d;
      man_a_q     <= man_a_d;
      man_b_q     <= man_b_d;
      exp_max_q   <= exp_max_d;
      man_big_q   <= man_big_d;
      man_sml_q   <= man_sml_d;
      swapped_q   <= swapped_d;
      shift_amt_q <= shift_amt_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.exp_max   = exp_max_q;
  assign bus.man_big   = man_big_q;
  assign bus.man_sml   = man_sml_q;
  assign bus.swapped   = swapped_q;
  assign bus.shift_amt = shift_amt_q;

endmodule
